acq_addr_seq: RTL and testbench

Parametrised ring-buffer address sequencer for the DSO/LA sample RAM. It is the successor to the plain write/read address generator. It adds:
- a programmable pre-trigger depth,
- an explicit acquisition state machine,
- a latched trigger address,
- wrap-aware read stepping from the start of the record.

It sits between the trigger logic and the external SRAM controller: write addresses during capture, read addresses during MCU readout.

---
 rtl/acq_addr_seq.sv | 149 ++++++++++++++
 tb/tb_acq_addr_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/acq_addr_seq.sv
// Ring-buffer address sequencer for the sample RAM: write addresses during capture, read addresses during readout.
// Latency: every output is registered; each state change or address update appears one cycle after its cause.
// Backpressure: none; writes are qualified by i_wr_inc and blocked outside FILL/ARMED/POST or while i_stop is high.
module acq_addr_seq #(
  parameter int AW = 18,
  parameter int SW = 8
) (
  input  logic          i_clk,
  input  logic          i_nrst,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic          i_trig,
  input  logic          i_wr_inc,
  input  logic [AW-1:0] i_pre_depth,
  input  logic          i_rd_load,
  input  logic          i_rd_inc,
  input  logic [SW-1:0] i_rd_step,
  output logic [AW-1:0] o_addr_wr,
  output logic [AW-1:0] o_addr_rd,
  output logic [AW-1:0] o_trig_addr,
  output logic [2:0]    o_state,
  output logic          o_done
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_ARMED = 3'd2;
  localparam logic [2:0] ST_POST  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Ring depth needs one extra bit: the post-trigger count can be the whole ring.
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [2:0]    r_state;
  logic [AW-1:0] r_addr_wr;
  logic [AW-1:0] r_addr_rd;
  logic [AW-1:0] r_trig_addr;
  logic [AW-1:0] r_pre;
  logic [AW-1:0] r_fill_cnt;
  logic [AW:0]   r_post_rem;
  logic          r_done;

  logic [2:0]    w_state_nxt;
  logic [AW-1:0] w_pre_nxt;
  logic [AW-1:0] w_fill_nxt;
  logic [AW:0]   w_post_nxt;
  logic [AW-1:0] w_trig_nxt;
  logic          w_write;
  logic [AW-1:0] w_fill_inc;
  logic [AW:0]   w_post_load;
  logic [AW:0]   w_post_dec;
  logic [AW-1:0] w_rec_start;
  logic [AW-1:0] w_rec_start_nxt;
  logic [AW-1:0] w_step_ext;
  logic [AW-1:0] w_addr_rd_nxt;
  logic          w_enter_done;

  // Acquisition control: next state, pre-trigger fill count, post-trigger countdown, trigger address.
  always_comb begin
    w_write     = i_wr_inc && !i_stop &&
                  ((r_state == ST_FILL) || (r_state == ST_ARMED) || (r_state == ST_POST));
    w_fill_inc  = r_fill_cnt + AW'(1);
    // The trigger sample itself is the first post-trigger write when it lands on the trigger cycle.
    w_post_load = DEPTH - {1'b0, r_pre} - {{AW{1'b0}}, w_write};
    w_post_dec  = r_post_rem - (AW+1)'(1);
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_fill_nxt  = r_fill_cnt;
    w_post_nxt  = r_post_rem;
    w_trig_nxt  = r_trig_addr;
    if (i_stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            // An AW-bit request never exceeds DEPTH-1, so it is already within range.
            w_pre_nxt   = i_pre_depth;
            w_fill_nxt  = '0;
            w_state_nxt = (i_pre_depth == '0) ? ST_ARMED : ST_FILL;
          end
        end
        ST_FILL: begin
          if (w_write) begin
            w_fill_nxt = w_fill_inc;
            if (w_fill_inc >= r_pre) w_state_nxt = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (i_trig) begin
            w_trig_nxt  = r_addr_wr;
            w_post_nxt  = w_post_load;
            w_state_nxt = (w_post_load == '0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (w_write) begin
            w_post_nxt = w_post_dec;
            if (w_post_dec == '0) w_state_nxt = ST_DONE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Read-side next address: automatic load on DONE entry, then explicit load, then signed step.
  always_comb begin
    w_enter_done    = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
    w_rec_start     = r_trig_addr - r_pre;
    // On DONE entry straight from ARMED the trigger address is not registered yet.
    w_rec_start_nxt = w_trig_nxt - r_pre;
    w_step_ext      = AW'($signed(i_rd_step));
    w_addr_rd_nxt   = r_addr_rd;
    if (w_enter_done)   w_addr_rd_nxt = w_rec_start_nxt;
    else if (i_rd_load) w_addr_rd_nxt = w_rec_start;
    else if (i_rd_inc)  w_addr_rd_nxt = r_addr_rd + w_step_ext;
  end

  // State and address registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_state     <= ST_IDLE;
      r_addr_wr   <= '0;
      r_addr_rd   <= '0;
      r_trig_addr <= '0;
      r_pre       <= '0;
      r_fill_cnt  <= '0;
      r_post_rem  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pre       <= w_pre_nxt;
      r_fill_cnt  <= w_fill_nxt;
      r_post_rem  <= w_post_nxt;
      r_trig_addr <= w_trig_nxt;
      r_addr_rd   <= w_addr_rd_nxt;
      r_done      <= (w_state_nxt == ST_DONE);
      if (w_write) r_addr_wr <= r_addr_wr + AW'(1);
    end
  end

  assign o_addr_wr   = r_addr_wr;
  assign o_addr_rd   = r_addr_rd;
  assign o_trig_addr = r_trig_addr;
  assign o_state     = r_state;
  assign o_done      = r_done;

endmodule

// File: tb/tb_acq_addr_seq.sv
// Bench for acq_addr_seq with a 16-entry ring: vector table driven cycle by cycle,
// expected outputs queued when the stimulus is applied and checked one edge later.
// No backpressure; every vector takes exactly one clock.
module tb_acq_addr_seq;

  localparam int AW = 4;
  localparam int SW = 8;

  logic          clk;
  logic          nrst;
  logic          start;
  logic          stop;
  logic          trig;
  logic          wr_inc;
  logic [AW-1:0] pre_depth;
  logic          rd_load;
  logic          rd_inc;
  logic [SW-1:0] rd_step;
  logic [AW-1:0] addr_wr;
  logic [AW-1:0] addr_rd;
  logic [AW-1:0] trig_addr;
  logic [2:0]    state;
  logic          done;

  acq_addr_seq #(.AW(AW), .SW(SW)) dut (
    .i_clk       (clk),
    .i_nrst      (nrst),
    .i_start     (start),
    .i_stop      (stop),
    .i_trig      (trig),
    .i_wr_inc    (wr_inc),
    .i_pre_depth (pre_depth),
    .i_rd_load   (rd_load),
    .i_rd_inc    (rd_inc),
    .i_rd_step   (rd_step),
    .o_addr_wr   (addr_wr),
    .o_addr_rd   (addr_rd),
    .o_trig_addr (trig_addr),
    .o_state     (state),
    .o_done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rn, st, sp, tr, wr, ld, inc;
    logic [7:0] step;
    logic [3:0] pre;
    logic [2:0] e_st;
    logic [3:0] e_aw, e_ar, e_ta;
  } vec_t;

  typedef struct {
    logic [2:0] e_st;
    logic [3:0] e_aw, e_ar, e_ta;
    logic       e_done;
  } exp_t;

  vec_t  vecs[$];
  string names[$];
  exp_t  exp_q[$];
  int    n_total = 0;
  int    n_bad   = 0;

  function automatic void add(string nm, logic rn, logic st, logic sp, logic tr, logic wr,
                              logic ld, logic inc, logic [7:0] step, logic [3:0] pre,
                              logic [2:0] es, int aw, int ar, int ta);
    vec_t v;
    v.rn = rn; v.st = st; v.sp = sp; v.tr = tr; v.wr = wr; v.ld = ld; v.inc = inc;
    v.step = step; v.pre = pre; v.e_st = es;
    v.e_aw = 4'(aw % 16); v.e_ar = 4'(ar % 16); v.e_ta = 4'(ta % 16);
    vecs.push_back(v);
    names.push_back(nm);
  endfunction

  task automatic chk(string nm, int idx, string field, logic [7:0] got, logic [7:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s[%0d].%s got=%0d want=%0d", nm, idx, field, got, want);
    end
  endtask

  initial begin
    exp_t e;
    nrst = 1'b0; start = 1'b0; stop = 1'b0; trig = 1'b0; wr_inc = 1'b0;
    pre_depth = '0; rd_load = 1'b0; rd_inc = 1'b0; rd_step = '0;

    // Reset: everything zero, IDLE.
    add("reset", 0, 0,0,0,0, 0,0, 8'h00, 0,  0, 0, 0, 0);

    // pre=4, continuous writes from addr 0; the start-cycle write is not a write (IDLE).
    add("start4", 1, 1,0,0,1, 0,0, 8'h00, 4,  1, 0, 0, 0);
    for (int k = 1; k <= 4; k++)
      add("fill4", 1, 0,0,0,1, 0,0, 8'h00, 4,  (k == 4) ? 3'd2 : 3'd1, k, 0, 0);
    for (int k = 5; k <= 10; k++)
      add("armed4", 1, 0,0,0,1, 0,0, 8'h00, 4,  2, k, 0, 0);
    add("trig4", 1, 0,0,1,1, 0,0, 8'h00, 4,  3, 11, 0, 10);
    for (int k = 1; k <= 11; k++)
      add("post4", 1, 0,0,0,1, 0,0, 8'h00, 4,  (k == 11) ? 3'd4 : 3'd3, 11 + k,
          (k == 11) ? 6 : 0, 10);
    add("done4_blocked", 1, 0,0,1,1, 0,0, 8'h00, 4,  4, 6, 6, 10);

    // pre=0: ARMED right after start, record starts at the trigger sample.
    add("start0", 1, 1,0,0,0, 0,0, 8'h00, 0,  2, 6, 6, 10);
    add("trig0", 1, 0,0,1,1, 0,0, 8'h00, 0,  3, 7, 6, 6);
    for (int k = 1; k <= 15; k++)
      add("post0", 1, 0,0,0,1, 0,0, 8'h00, 0,  (k == 15) ? 3'd4 : 3'd3, 7 + k, 6, 6);

    // pre=15 (largest representable with a 4-bit ring): DONE on the trigger cycle,
    // trigger placed at address 0 so the record starts at 1.
    add("start15", 1, 1,0,0,0, 0,0, 8'h00, 15,  1, 6, 6, 6);
    for (int k = 1; k <= 15; k++)
      add("fill15", 1, 0,0,0,1, 0,0, 8'h00, 15,  (k == 15) ? 3'd2 : 3'd1, 6 + k, 6, 6);
    for (int k = 1; k <= 11; k++)
      add("armed15", 1, 0,0,0,1, 0,0, 8'h00, 15,  2, 5 + k, 6, 6);
    // rd_inc on the DONE-entry cycle must not disturb the automatic load.
    add("trig15_inc_ignored", 1, 0,0,1,1, 0,1, 8'h03, 15,  4, 1, 1, 0);

    // Read stepping with wrap below zero, and load-over-increment priority.
    add("rd_load", 1, 0,0,0,0, 1,0, 8'hFF, 15,  4, 1, 1, 0);
    add("rd_dec1", 1, 0,0,0,0, 0,1, 8'hFF, 15,  4, 1, 0, 0);
    add("rd_dec2", 1, 0,0,0,0, 0,1, 8'hFF, 15,  4, 1, 15, 0);
    add("rd_dec3", 1, 0,0,0,0, 0,1, 8'hFF, 15,  4, 1, 14, 0);
    add("rd_ld_inc", 1, 0,0,0,0, 1,1, 8'hFF, 15,  4, 1, 1, 0);
    add("rd_inc_pos", 1, 0,0,0,0, 0,1, 8'h05, 15,  4, 1, 6, 0);

    // Gated writes, pre=2: trig in FILL ignored, counts move only on writes.
    add("start2", 1, 1,0,0,0, 0,0, 8'h00, 2,  1, 1, 6, 0);
    add("g_fill_trig", 1, 0,0,1,0, 0,0, 8'h00, 2,  1, 1, 6, 0);
    add("g_fill_idle", 1, 0,0,0,0, 0,0, 8'h00, 2,  1, 1, 6, 0);
    add("g_fill_w1", 1, 0,0,0,1, 0,0, 8'h00, 2,  1, 2, 6, 0);
    add("g_fill_idle", 1, 0,0,0,0, 0,0, 8'h00, 2,  1, 2, 6, 0);
    add("g_fill_trig2", 1, 0,0,1,0, 0,0, 8'h00, 2,  1, 2, 6, 0);
    add("g_fill_w2", 1, 0,0,0,1, 0,0, 8'h00, 2,  2, 3, 6, 0);
    add("g_armed_idle", 1, 0,0,0,0, 0,0, 8'h00, 2,  2, 3, 6, 0);
    add("g_trig_nowr", 1, 0,0,1,0, 0,0, 8'h00, 2,  3, 3, 6, 3);
    add("g_post_w1", 1, 0,0,0,1, 0,0, 8'h00, 2,  3, 4, 6, 3);
    add("g_post_idle", 1, 0,0,1,0, 0,0, 8'h00, 2,  3, 4, 6, 3);
    add("g_post_idle", 1, 0,0,0,0, 0,0, 8'h00, 2,  3, 4, 6, 3);
    add("g_post_w2", 1, 0,0,0,1, 0,0, 8'h00, 2,  3, 5, 6, 3);
    add("g_start_in_post", 1, 1,0,0,0, 0,0, 8'h00, 7,  3, 5, 6, 3);
    add("g_stop", 1, 1,1,1,1, 0,0, 8'h00, 7,  0, 5, 6, 3);
    add("g_idle_wr", 1, 0,0,1,1, 0,0, 8'h00, 7,  0, 5, 6, 3);

    // Reset in the middle of POST, then a fresh acquisition.
    add("start1", 1, 1,0,0,0, 0,0, 8'h00, 1,  1, 5, 6, 3);
    add("fill1", 1, 0,0,0,1, 0,0, 8'h00, 1,  2, 6, 6, 3);
    add("trig1", 1, 0,0,1,1, 0,0, 8'h00, 1,  3, 7, 6, 6);
    add("rst_mid_post", 0, 1,0,1,1, 1,1, 8'h01, 1,  0, 0, 0, 0);
    add("restart0", 1, 1,0,0,0, 0,0, 8'h00, 0,  2, 0, 0, 0);
    add("retrig0", 1, 0,0,1,1, 0,0, 8'h00, 0,  3, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      nrst = vecs[i].rn; start = vecs[i].st; stop = vecs[i].sp; trig = vecs[i].tr;
      wr_inc = vecs[i].wr; rd_load = vecs[i].ld; rd_inc = vecs[i].inc;
      rd_step = vecs[i].step; pre_depth = vecs[i].pre;
      e.e_st = vecs[i].e_st; e.e_aw = vecs[i].e_aw; e.e_ar = vecs[i].e_ar;
      e.e_ta = vecs[i].e_ta; e.e_done = (vecs[i].e_st == 3'd4);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk(names[i], i, "state",     {5'b0, state},     {5'b0, e.e_st});
      chk(names[i], i, "addr_wr",   {4'b0, addr_wr},   {4'b0, e.e_aw});
      chk(names[i], i, "addr_rd",   {4'b0, addr_rd},   {4'b0, e.e_ar});
      chk(names[i], i, "trig_addr", {4'b0, trig_addr}, {4'b0, e.e_ta});
      chk(names[i], i, "done",      {7'b0, done},      {7'b0, e.e_done});
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
